// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared definitions for operand forwarding and load-use hazard control.
// The execute stage decodes FU_Src_Sel/FU_Dst_Sel with the same SEL_* codes.
package forwarding_hazard_unit_pkg;

  // Forwarding select codes seen by the execute-stage operand muxes
  localparam logic [1:0] SEL_MUX   = 2'b00;  // regfile / immediate mux
  localparam logic [1:0] SEL_WB    = 2'b01;  // final write-back data (load result)
  localparam logic [1:0] SEL_EXMEM = 2'b10;  // ALU result held in EX/MEM
  localparam logic [1:0] SEL_MEMWB = 2'b11;  // ALU result held in MEM/WB

  // Load-use controller states
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } fsm_state_e;

  // Tag pipe stage indices, youngest first
  localparam int NUM_STAGES = 3;
  localparam int STG_EX     = 0;
  localparam int STG_MEM    = 1;
  localparam int STG_WB     = 2;

  // Stages whose producers can still be forwarded to a decoding consumer.
  // A WB producer writes the regfile before decode reads it.
  localparam logic [NUM_STAGES-1:0] FWD_STAGE_MASK = 3'b011;
  // Stages where a matching load is not yet able to supply its data
  localparam logic [NUM_STAGES-1:0] HAZ_STAGE_MASK = 3'b001;

  // A-side select: EX/MEM ALU result is youngest; a MEM-stage load is
  // taken from the final WB data, a MEM-stage ALU op from MEM/WB.
  function automatic logic [1:0] src_sel_f(input logic ex_hit, input logic ex_ld,
                                           input logic mem_hit, input logic mem_ld);
    if (ex_hit && !ex_ld) return SEL_EXMEM;
    if (mem_hit) return mem_ld ? SEL_WB : SEL_MEMWB;
    return SEL_MUX;
  endfunction

  // B-side select: the B mux has no MEM/WB ALU input, so any MEM-stage
  // producer is taken from the WB data path.
  function automatic logic [1:0] dst_sel_f(input logic ex_hit, input logic ex_ld,
                                           input logic mem_hit);
    if (ex_hit && !ex_ld) return SEL_EXMEM;
    if (mem_hit) return SEL_WB;
    return SEL_MUX;
  endfunction

endpackage

// File: rtl/forwarding_hazard_unit_hazard_tag_pipe.sv
// Three-stage shift register of destination tags {v,we,wa,ld} that
// follows instructions through EX, MEM and WB. A bubble enters as an
// all-zero slot; hold freezes every stage.
module hazard_tag_pipe
  import forwarding_hazard_unit_pkg::*;
#(
  parameter int RA = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           hold,
  input  logic                           slot_v,
  input  logic                           slot_we,
  input  logic [RA-1:0]                  slot_wa,
  input  logic                           slot_ld,
  output logic [NUM_STAGES-1:0]          tag_v,
  output logic [NUM_STAGES-1:0]          tag_we,
  output logic [NUM_STAGES-1:0][RA-1:0]  tag_wa,
  output logic [NUM_STAGES-1:0]          tag_ld
);

  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
    logic          v_in, we_in, ld_in;
    logic [RA-1:0] wa_in;
    logic          v_reg, we_reg, ld_reg;
    logic [RA-1:0] wa_reg;

    if (gi == 0) begin : g_head
      assign v_in  = slot_v;
      assign we_in = slot_we;
      assign wa_in = slot_wa;
      assign ld_in = slot_ld;
    end else begin : g_body
      assign v_in  = tag_v[gi-1];
      assign we_in = tag_we[gi-1];
      assign wa_in = tag_wa[gi-1];
      assign ld_in = tag_ld[gi-1];
    end

    // Advance the tag one stage per edge unless the pipeline is frozen
    always_ff @(posedge clk) begin
      if (!rst) begin
        v_reg  <= 1'b0;
        we_reg <= 1'b0;
        wa_reg <= '0;
        ld_reg <= 1'b0;
      end else if (!hold) begin
        v_reg  <= v_in;
        we_reg <= we_in;
        wa_reg <= wa_in;
        ld_reg <= ld_in;
      end
    end

    assign tag_v[gi]  = v_reg;
    assign tag_we[gi] = we_reg;
    assign tag_wa[gi] = wa_reg;
    assign tag_ld[gi] = ld_reg;
  end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Operand forwarding select generator and load-use hazard controller.
// Decode-stage sources are compared against in-flight destination tags;
// the resulting selects are registered so they reach EX with the consumer.
module forwarding_hazard_unit
  import forwarding_hazard_unit_pkg::*;
#(
  parameter int RA         = 3,
  parameter int LOAD_STALL = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [RA-1:0] id_rsrc,
  input  logic [RA-1:0] id_rdst,
  input  logic          id_use_src,
  input  logic          id_use_dst,
  input  logic          id_we,
  input  logic [RA-1:0] id_wa,
  input  logic          id_is_load,
  input  logic          stall_in,
  input  logic          flush_in,
  output logic [1:0]    FU_Src_Sel,
  output logic [1:0]    FU_Dst_Sel,
  output logic          stall_out,
  output logic          bubble_out
);

  // Extra stall cycles spent in ST_STALL after the detecting cycle
  localparam logic [1:0] STALL_EXTRA = 2'(LOAD_STALL - 1);

  logic                          slot_v;
  logic [NUM_STAGES-1:0]         tag_v, tag_we, tag_ld;
  logic [NUM_STAGES-1:0][RA-1:0] tag_wa;
  logic [NUM_STAGES-1:0]         src_hit, dst_hit;
  logic [NUM_STAGES-1:0]         src_fwd, dst_fwd, ld_hit;
  logic                          hazard;
  logic [1:0]                    src_sel_next, dst_sel_next;
  logic [1:0]                    src_sel_reg, dst_sel_reg;
  fsm_state_e                    state_reg;
  logic [1:0]                    cnt_reg;

  // Decode slot entering ID/EX; killed by flush, hazard bubble or no instruction
  assign slot_v = id_valid & ~flush_in & ~bubble_out;

  hazard_tag_pipe #(.RA(RA)) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .hold    (stall_in),
    .slot_v  (slot_v),
    .slot_we (slot_v & id_we),
    .slot_wa (slot_v ? id_wa : '0),
    .slot_ld (slot_v & id_is_load),
    .tag_v   (tag_v),
    .tag_we  (tag_we),
    .tag_wa  (tag_wa),
    .tag_ld  (tag_ld)
  );

  // Per-stage tag comparators for both operand sides
  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_cmp
    assign src_hit[gi] = tag_v[gi] & tag_we[gi] & (tag_wa[gi] == id_rsrc) & id_use_src;
    assign dst_hit[gi] = tag_v[gi] & tag_we[gi] & (tag_wa[gi] == id_rdst) & id_use_dst;
  end

  assign src_fwd = src_hit & FWD_STAGE_MASK;
  assign dst_fwd = dst_hit & FWD_STAGE_MASK;
  assign ld_hit  = (src_hit | dst_hit) & tag_ld & HAZ_STAGE_MASK;
  assign hazard  = id_valid & ~flush_in & (|ld_hit);

  // Priority select: youngest forwardable producer wins
  always_comb begin
    src_sel_next = SEL_MUX;
    dst_sel_next = SEL_MUX;
    if (|src_fwd) begin
      src_sel_next = src_sel_f(src_fwd[STG_EX], tag_ld[STG_EX],
                               src_fwd[STG_MEM], tag_ld[STG_MEM]);
    end
    if (|dst_fwd) begin
      dst_sel_next = dst_sel_f(dst_fwd[STG_EX], tag_ld[STG_EX], dst_fwd[STG_MEM]);
    end
  end

  // Selects travel with the ID/EX slot; bubbles and flushes carry SEL_MUX
  always_ff @(posedge clk) begin
    if (!rst) begin
      src_sel_reg <= SEL_MUX;
      dst_sel_reg <= SEL_MUX;
    end else if (!stall_in) begin
      src_sel_reg <= slot_v ? src_sel_next : SEL_MUX;
      dst_sel_reg <= slot_v ? dst_sel_next : SEL_MUX;
    end
  end

  // Load-use controller: the detecting cycle stalls in RUN, further cycles in STALL
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_RUN;
      cnt_reg   <= 2'd0;
    end else if (!stall_in) begin
      case (state_reg)
        ST_RUN: begin
          if (hazard && (LOAD_STALL > 1)) begin
            state_reg <= ST_STALL;
            cnt_reg   <= STALL_EXTRA;
          end
        end
        ST_STALL: begin
          if (flush_in) begin
            state_reg <= ST_RUN;
            cnt_reg   <= 2'd0;
          end else begin
            cnt_reg <= cnt_reg - 2'd1;
            if (cnt_reg == 2'd1) state_reg <= ST_RUN;
          end
        end
        default: begin
          state_reg <= ST_RUN;
          cnt_reg   <= 2'd0;
        end
      endcase
    end
  end

  assign stall_out  = (state_reg == ST_STALL) | hazard;
  assign bubble_out = stall_out;
  assign FU_Src_Sel = src_sel_reg;
  assign FU_Dst_Sel = dst_sel_reg;

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Scoreboard bench for forwarding_hazard_unit. The driver computes the
// expected per-cycle outputs from an in-flight instruction history and
// queues them; the monitor pops and compares on every falling edge.
module tb_forwarding_hazard_unit;

  localparam int RA = 3;
  localparam int LS = 2;

  logic          clk = 1'b0;
  logic          rst, id_valid, id_use_src, id_use_dst, id_we, id_is_load;
  logic          stall_in, flush_in;
  logic [RA-1:0] id_rsrc, id_rdst, id_wa;
  logic [1:0]    FU_Src_Sel, FU_Dst_Sel;
  logic          stall_out, bubble_out;

  always #5 clk = ~clk;

  forwarding_hazard_unit #(.RA(RA), .LOAD_STALL(LS)) dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_rsrc    (id_rsrc),
    .id_rdst    (id_rdst),
    .id_use_src (id_use_src),
    .id_use_dst (id_use_dst),
    .id_we      (id_we),
    .id_wa      (id_wa),
    .id_is_load (id_is_load),
    .stall_in   (stall_in),
    .flush_in   (flush_in),
    .FU_Src_Sel (FU_Src_Sel),
    .FU_Dst_Sel (FU_Dst_Sel),
    .stall_out  (stall_out),
    .bubble_out (bubble_out)
  );

  typedef struct packed {
    logic       v;
    logic [2:0] rs;
    logic       us;
    logic [2:0] rd;
    logic       ud;
    logic       we;
    logic [2:0] wa;
    logic       ld;
  } instr_t;

  typedef struct {
    bit       v;
    bit       we;
    bit [2:0] wa;
    bit       ld;
  } prod_t;

  typedef struct {
    int       cyc;
    bit [1:0] src;
    bit [1:0] dst;
    bit       stall;
    bit       bubble;
  } exp_t;

  exp_t  sb[$];
  prod_t hist[$];        // hist[0] entered ID/EX most recently
  bit [1:0] m_src, m_dst;
  int    m_rem;          // forced stall cycles still owed after the current one
  int    tests = 0;
  int    fails = 0;
  int    cyc   = 0;
  exp_t  mon_e;

  function automatic instr_t mk(bit v, bit [2:0] rs, bit us, bit [2:0] rd, bit ud,
                                bit we, bit [2:0] wa, bit ld);
    instr_t r;
    r.v = v; r.rs = rs; r.us = us; r.rd = rd; r.ud = ud;
    r.we = we; r.wa = wa; r.ld = ld;
    return r;
  endfunction

  function automatic instr_t nop();             return mk(0, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic instr_t alu(bit [2:0] n);  return mk(1, 0, 0, 0, 0, 1, n, 0); endfunction
  function automatic instr_t ldd(bit [2:0] n);  return mk(1, 0, 0, 0, 0, 1, n, 1); endfunction
  function automatic instr_t use_a(bit [2:0] n); return mk(1, n, 1, 7, 0, 0, 0, 0); endfunction
  function automatic instr_t use_b(bit [2:0] n); return mk(1, 7, 0, n, 1, 0, 0, 0); endfunction

  // Producer that entered ID/EX 'age' advances ago writes register r
  function automatic bit hit(int age, bit [2:0] r, bit use_it);
    return use_it && hist[age].v && hist[age].we && (hist[age].wa == r);
  endfunction

  // Where the consumer's operand comes from once it reaches EX: the youngest
  // producer one advance ahead sits in EX/MEM, two ahead has reached MEM/WB
  // (ALU result, A side only) or final write-back (loads, and all B side).
  function automatic bit [1:0] fwd_sel(bit [2:0] r, bit use_it, bit is_src);
    for (int age = 0; age < 2; age++) begin
      if (hit(age, r, use_it)) begin
        if (age == 0) return hist[0].ld ? 2'b00 : 2'b10;
        if (hist[1].ld || !is_src) return 2'b01;
        return 2'b11;
      end
    end
    return 2'b00;
  endfunction

  task automatic model_reset();
    prod_t z;
    z = '{v: 0, we: 0, wa: 0, ld: 0};
    hist.delete();
    repeat (3) hist.push_back(z);
    m_src = 0;
    m_dst = 0;
    m_rem = 0;
  endtask

  // One clock cycle: drive, queue the expectation, then advance the model
  task automatic step(input instr_t i, input bit si, input bit fl, input bit rn);
    bit       h, st, sv;
    bit [1:0] ns, nd;
    exp_t     e;
    prod_t    p;
    rst = rn; id_valid = i.v; id_rsrc = i.rs; id_use_src = i.us;
    id_rdst = i.rd; id_use_dst = i.ud; id_we = i.we; id_wa = i.wa;
    id_is_load = i.ld; stall_in = si; flush_in = fl;
    h  = (m_rem == 0) && i.v && !fl && hist[0].ld &&
         (hit(0, i.rs, i.us) || hit(0, i.rd, i.ud));
    st = (m_rem > 0) || h;
    e  = '{cyc: cyc, src: m_src, dst: m_dst, stall: st, bubble: st};
    sb.push_back(e);
    sv = i.v && !fl && !st;
    ns = sv ? fwd_sel(i.rs, i.us, 1'b1) : 2'b00;
    nd = sv ? fwd_sel(i.rd, i.ud, 1'b0) : 2'b00;
    @(posedge clk);
    if (!rn) begin
      model_reset();
    end else if (!si) begin
      p.v = sv; p.we = sv && i.we; p.wa = sv ? i.wa : 3'd0; p.ld = sv && i.ld;
      hist.push_front(p);
      void'(hist.pop_back());
      m_src = ns;
      m_dst = nd;
      if (m_rem == 0) m_rem = h ? LS - 1 : 0;
      else            m_rem = fl ? 0 : m_rem - 1;
    end
    cyc++;
    #1;
  endtask

  task automatic chk(input string nm, input int c, input logic [1:0] act, input logic [1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s cyc %0d: got %0b want %0b", nm, c, act, req);
    end
  endtask

  // Monitor: the DUT presents a fresh set of outputs every cycle
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("src_sel", mon_e.cyc, FU_Src_Sel, mon_e.src);
        chk("dst_sel", mon_e.cyc, FU_Dst_Sel, mon_e.dst);
        chk("stall",   mon_e.cyc, {1'b0, stall_out},  {1'b0, mon_e.stall});
        chk("bubble",  mon_e.cyc, {1'b0, bubble_out}, {1'b0, mon_e.bubble});
        $display("[TB] cyc %0d src=%0d dst=%0d stall=%0d bubble=%0d", mon_e.cyc,
                 FU_Src_Sel, FU_Dst_Sel, stall_out, bubble_out);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    instr_t r;
    rst = 0; id_valid = 0; id_rsrc = 0; id_rdst = 0; id_use_src = 0; id_use_dst = 0;
    id_we = 0; id_wa = 0; id_is_load = 0; stall_in = 0; flush_in = 0;
    @(posedge clk);
    #1;
    model_reset();
    step(nop(), 0, 0, 0);
    step(nop(), 0, 0, 1);

    // ALU result forwarded from EX/MEM
    step(alu(1), 0, 0, 1); step(use_a(1), 0, 0, 1); step(nop(), 0, 0, 1);
    repeat (2) step(nop(), 0, 0, 1);
    // Two-ahead producer: B side via WB, A side via MEM/WB
    step(alu(2), 0, 0, 1); step(nop(), 0, 0, 1); step(use_b(2), 0, 0, 1); step(nop(), 0, 0, 1);
    repeat (2) step(nop(), 0, 0, 1);
    step(alu(2), 0, 0, 1); step(nop(), 0, 0, 1); step(use_a(2), 0, 0, 1); step(nop(), 0, 0, 1);
    repeat (2) step(nop(), 0, 0, 1);
    // Load-use: consumer held in decode through the stall cycles
    step(ldd(3), 0, 0, 1); repeat (3) step(use_a(3), 0, 0, 1); step(nop(), 0, 0, 1);
    repeat (2) step(nop(), 0, 0, 1);
    // Load two ahead without a stall: WB data path
    step(ldd(3), 0, 0, 1); step(nop(), 0, 0, 1); step(use_b(3), 0, 0, 1); step(nop(), 0, 0, 1);
    repeat (2) step(nop(), 0, 0, 1);
    // Youngest producer wins; unused operand never forwards
    step(alu(4), 0, 0, 1); step(alu(4), 0, 0, 1); step(use_a(4), 0, 0, 1); step(nop(), 0, 0, 1);
    step(alu(4), 0, 0, 1); step(mk(1, 4, 0, 4, 0, 0, 0, 0), 0, 0, 1); step(nop(), 0, 0, 1);
    repeat (2) step(nop(), 0, 0, 1);
    // Flush suppresses the load-use stall
    step(ldd(5), 0, 0, 1); step(use_a(5), 0, 1, 1); step(nop(), 0, 0, 1);
    repeat (2) step(nop(), 0, 0, 1);
    // External freeze for three cycles mid-stream
    step(alu(6), 0, 0, 1); repeat (3) step(use_a(6), 1, 0, 1);
    step(use_a(6), 0, 0, 1); step(nop(), 0, 0, 1);
    // Flush aborts a STALL sequence
    step(ldd(2), 0, 0, 1); step(use_a(2), 0, 0, 1); step(use_a(2), 0, 1, 1);
    step(use_a(2), 0, 0, 1); step(nop(), 0, 0, 1);
    repeat (2) step(nop(), 0, 0, 1);
    // Reset taken while in STALL
    step(ldd(1), 0, 0, 1); step(use_b(1), 0, 0, 1); step(use_b(1), 0, 0, 0);
    step(use_b(1), 0, 0, 1); step(nop(), 0, 0, 1);

    // Randomized instruction stream over a small register set
    for (int n = 0; n < 400; n++) begin
      r = mk($urandom_range(0, 99) < 85, 3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 99) < 70,
             3'($urandom_range(0, 3)), $urandom_range(0, 99) < 35);
      step(r, $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 8,
           $urandom_range(0, 99) != 0);
    end

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
